// File: rtl/sc_stream_decoder_if.sv
// ----------------------------------------------------------------------------
// sc_stream_decoder_if
//   Handshake and stream bundle between a controller/stochastic source and the
//   stochastic-to-binary decoder.
//   master : drives start, abort, z, z_valid; observes busy, done,
//            result_valid, count
//   slave  : the decoder side (mirror of master)
//   LOG_LEN must match the LOG_LEN of the decoder it is bound to.
// ----------------------------------------------------------------------------
interface sc_stream_decoder_if #(
    parameter int LOG_LEN = 8
);
    logic               start;
    logic               abort;
    logic               z;
    logic               z_valid;
    logic               busy;
    logic               done;
    logic               result_valid;
    logic [LOG_LEN:0]   count;

    modport master (
        output start, abort, z, z_valid,
        input  busy, done, result_valid, count
    );

    modport slave (
        input  start, abort, z, z_valid,
        output busy, done, result_valid, count
    );
endinterface

// File: rtl/sc_stream_decoder.sv
// ----------------------------------------------------------------------------
// sc_stream_decoder
//   Counts the ones in a window of 2**LOG_LEN valid stochastic stream bits and
//   returns the count (unipolar estimate = count / 2**LOG_LEN).
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : sc_stream_decoder_if.slave
//              in  start, abort, z, z_valid
//              out busy, done (1-cycle pulse), result_valid, count[LOG_LEN:0]
//   All outputs are registered. start is accepted only in IDLE; abort wins
//   over start and over the last sample of a window.
// ----------------------------------------------------------------------------
module sc_stream_decoder #(
    parameter int LOG_LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sc_stream_decoder_if.slave   bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [LOG_LEN:0]    r_acc;
    logic [LOG_LEN-1:0]  r_smp;
    logic [LOG_LEN:0]    r_count;
    logic                r_busy;
    logic                r_done;
    logic                r_result_valid;

    logic [LOG_LEN:0]    w_acc_next;
    logic                w_last;

    // acc has one bit more than the window index, so the all-ones window
    // (2**LOG_LEN) fits without wrap.
    assign w_acc_next = r_acc + {{LOG_LEN{1'b0}}, bus.z};
    assign w_last     = (r_smp == {LOG_LEN{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_acc          <= '0;
            r_smp          <= '0;
            r_count        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // z on the start cycle is deliberately not sampled
                    if (bus.start && !bus.abort) begin
                        r_state        <= S_RUN;
                        r_busy         <= 1'b1;
                        r_acc          <= '0;
                        r_smp          <= '0;
                        r_result_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        // count and result_valid are left as they are
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.z_valid) begin
                        r_acc <= w_acc_next;
                        r_smp <= r_smp + 1'b1;   // wraps to 0 on the last sample
                        if (w_last) begin
                            r_count        <= w_acc_next;
                            r_done         <= 1'b1;
                            r_result_valid <= 1'b1;
                            r_busy         <= 1'b0;
                            r_state        <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.result_valid = r_result_valid;
    assign bus.count        = r_count;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// ----------------------------------------------------------------------------
// tb_sc_stream_decoder
//   Directed bench for sc_stream_decoder with LOG_LEN=4 (16-sample window).
//   Cycle numbering: cycle c starts at a rising edge; outputs are checked and
//   inputs driven 1 time unit after that edge.
// ----------------------------------------------------------------------------
module tb_sc_stream_decoder;

    localparam int LOG_LEN = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   k;

    sc_stream_decoder_if #(.LOG_LEN(LOG_LEN)) bus ();

    sc_stream_decoder #(.LOG_LEN(LOG_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.z       = 1'b0;
        bus.z_valid = 1'b0;

        // ---- reset state
        tick();
        tick();
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_rv",    int'(bus.result_valid), 0);
        chk("rst_count", int'(bus.count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- 1: all ones, no stalls
        bus.start = 1'b1; bus.z = 1'b1; bus.z_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            bus.start = 1'b0;
            chk("t1_busy", int'(bus.busy), int'(c <= 16));
            chk("t1_done", int'(bus.done), int'(c == 17));
        end
        chk("t1_count", int'(bus.count), 16);
        chk("t1_rv", int'(bus.result_valid), 1);
        tick();
        chk("t1_done_c18", int'(bus.done), 0);
        chk("t1_rv_c18", int'(bus.result_valid), 1);

        // ---- 2: all zeros
        bus.start = 1'b1; bus.z = 1'b0; bus.z_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            bus.start = 1'b0;
            if (c == 1) chk("t2_rv_clr", int'(bus.result_valid), 0);
            chk("t2_done", int'(bus.done), int'(c == 17));
        end
        chk("t2_count", int'(bus.count), 0);
        chk("t2_rv", int'(bus.result_valid), 1);

        // ---- 3: alternating 1,0 on valid samples; stall every 3rd cycle (z=1
        //      during stalls so any sampling there would inflate the count)
        k = 0;
        bus.start = 1'b1; bus.z = 1'b0; bus.z_valid = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            bus.start = 1'b0;
            chk("t3_busy", int'(bus.busy), int'(c <= 24));
            chk("t3_done", int'(bus.done), int'(c == 25));
            if (c % 3 == 2) begin
                bus.z_valid = 1'b0; bus.z = 1'b1;
            end else begin
                bus.z_valid = 1'b1; bus.z = (k % 2 == 0); k++;
            end
        end
        chk("t3_count", int'(bus.count), 8);

        // ---- 4a: abort at c6
        bus.start = 1'b1; bus.z = 1'b1; bus.z_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus.start = 1'b0;
            bus.abort = (c == 6);
            chk("t4_busy", int'(bus.busy), int'(c <= 6));
            chk("t4_done", int'(bus.done), 0);
        end
        chk("t4_rv", int'(bus.result_valid), 0);
        chk("t4_count", int'(bus.count), 8);

        // ---- 4b: abort together with start in IDLE
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("t4_abort_idle_busy", int'(bus.busy), 0);
        tick();
        chk("t4_abort_idle_busy2", int'(bus.busy), 0);

        // ---- 4c: abort on the last-sample cycle
        bus.start = 1'b1; bus.z = 1'b1; bus.z_valid = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            bus.start = 1'b0;
            bus.abort = (c == 16);
            chk("t4_last_busy", int'(bus.busy), int'(c <= 16));
            chk("t4_last_done", int'(bus.done), 0);
        end
        chk("t4_last_count", int'(bus.count), 8);
        chk("t4_last_rv", int'(bus.result_valid), 0);

        // ---- 4d: fresh window after aborts; z on the start cycle is 1 but
        //      must not count
        bus.start = 1'b1; bus.z = 1'b1; bus.z_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            bus.start = 1'b0;
            bus.z = (c <= 5);
            chk("t4_new_done", int'(bus.done), int'(c == 17));
        end
        chk("t4_new_count", int'(bus.count), 5);
        chk("t4_new_rv", int'(bus.result_valid), 1);

        // ---- 5: start ignored in RUN, then back-to-back start on done cycle
        bus.start = 1'b1; bus.z = 1'b1; bus.z_valid = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            bus.start = (c == 5 || c == 17);
            bus.z = (c <= 16) ? 1'b1 : (c % 4 == 0);
            chk("t5_busy", int'(bus.busy), int'((c >= 1 && c <= 16) || (c >= 18 && c <= 33)));
            chk("t5_done", int'(bus.done), int'(c == 17 || c == 34));
            if (c == 17) chk("t5_count_a", int'(bus.count), 16);
            if (c == 34) chk("t5_count_b", int'(bus.count), 4);
        end

        // ---- 6: asynchronous reset mid-window
        bus.start = 1'b1; bus.z = 1'b1; bus.z_valid = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.start = 1'b0;
        end
        chk("t6_busy_pre", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy",  int'(bus.busy), 0);
        chk("t6_done",  int'(bus.done), 0);
        chk("t6_rv",    int'(bus.result_valid), 0);
        chk("t6_count", int'(bus.count), 0);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t6_idle_busy", int'(bus.busy), 0);
            chk("t6_idle_done", int'(bus.done), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
